// File: rtl/quad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : quad_pkg
// Description : Shared definitions for the quadrature decoder: phase
//               constants, FSM state encodings, error counter width and the
//               (A,B) -> phase encode function.
// Revision    : 1.0 - initial release
// ============================================================================
package quad_pkg;

  localparam int ERR_CNT_W = 8;

  // Quadrature phases in generator order 10 -> 11 -> 01 -> 00
  localparam logic [1:0] PH_0 = 2'd0;
  localparam logic [1:0] PH_1 = 2'd1;
  localparam logic [1:0] PH_2 = 2'd2;
  localparam logic [1:0] PH_3 = 2'd3;

  // Decoder FSM states
  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_TRACK = 1'b1;

  // Map a filtered (A,B) pair onto its phase index; forward motion is +1 mod 4
  function automatic logic [1:0] phase_enc(input logic a, input logic b);
    logic [1:0] ph;
    case ({a, b})
      2'b10:   ph = PH_0;
      2'b11:   ph = PH_1;
      2'b01:   ph = PH_2;
      default: ph = PH_3;
    endcase
    return ph;
  endfunction

endpackage : quad_pkg
`default_nettype wire

// File: rtl/quad_sync_filter.sv
`default_nettype none
// ============================================================================
// Module      : quad_sync_filter
// Description : Two-bit synchronizer chain followed by a stability filter.
//               A new (A,B) value is accepted only after FILT_LEN consecutive
//               identical synchronized samples that differ from the current
//               filtered value. changed_o pulses for one cycle on acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
module quad_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] raw_i,
  output logic [1:0] filt_o,
  output logic       changed_o
);

  localparam int              RUN_W    = $clog2(FILT_LEN + 1);
  localparam logic [RUN_W-1:0] C_FILT  = RUN_W'(FILT_LEN);
  localparam logic [RUN_W-1:0] C_ONE   = RUN_W'(1);

  logic [SYNC_STAGES-1:0][1:0] sync_q;
  logic [SYNC_STAGES-1:0]      fill_q;

  logic [1:0]       filt_q,    filt_d;
  logic             filt_vld_q, filt_vld_d;
  logic [1:0]       cand_q,    cand_d;
  logic [RUN_W-1:0] run_q,     run_d;
  logic             changed_q, changed_d;

  logic [1:0]       w_sync;
  logic             w_sync_vld;
  logic             w_differs;
  logic [RUN_W-1:0] w_run;

  // Shift raw pins through the synchronizer; fill_q marks stages holding real samples
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign w_sync     = sync_q[SYNC_STAGES-1];
  assign w_sync_vld = fill_q[SYNC_STAGES-1];
  // Before the first acceptance there is no filtered value, so anything counts as new
  assign w_differs  = !filt_vld_q || (w_sync != filt_q);
  assign w_run      = ((run_q != '0) && (w_sync == cand_q)) ? (run_q + C_ONE) : C_ONE;

  // Count the run length of a candidate and promote it once the run is long enough
  always_comb begin
    filt_d     = filt_q;
    filt_vld_d = filt_vld_q;
    cand_d     = cand_q;
    run_d      = run_q;
    changed_d  = 1'b0;
    if (w_sync_vld) begin
      if (!w_differs) begin
        run_d = '0;
      end else begin
        cand_d = w_sync;
        if (w_run >= C_FILT) begin
          filt_d     = w_sync;
          filt_vld_d = 1'b1;
          changed_d  = 1'b1;
          run_d      = '0;
        end else begin
          run_d = w_run;
        end
      end
    end
  end

  // Filter state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q     <= '0;
      filt_vld_q <= 1'b0;
      cand_q     <= '0;
      run_q      <= '0;
      changed_q  <= 1'b0;
    end else begin
      filt_q     <= filt_d;
      filt_vld_q <= filt_vld_d;
      cand_q     <= cand_d;
      run_q      <= run_d;
      changed_q  <= changed_d;
    end
  end

  assign filt_o    = filt_q;
  assign changed_o = changed_q;

endmodule : quad_sync_filter
`default_nettype wire

// File: rtl/quad_decoder.sv
`default_nettype none
// ============================================================================
// Module      : quad_decoder
// Description : Quadrature receiver. Synchronizes and filters A/B, decodes
//               legal phase steps into a modulo position count and direction,
//               and flags/counts illegal two-bit transitions.
// Revision    : 1.0 - initial release
// ============================================================================
module quad_decoder
  import quad_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sq_a,
  input  logic                 sq_b,
  input  logic                 clear,
  output logic [CNT_W-1:0]     position,
  output logic                 dir,
  output logic                 step,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0]     C_POS_ONE = CNT_W'(1);
  localparam logic [ERR_CNT_W-1:0] C_ERR_ONE = ERR_CNT_W'(1);

  logic [1:0] w_filt;
  logic       w_changed;
  logic [1:0] w_new_ph;
  logic [1:0] w_delta;

  logic [0:0]           state_q,   state_d;
  logic [1:0]           phase_q,   phase_d;
  logic [CNT_W-1:0]     pos_q,     pos_d;
  logic                 dir_q,     dir_d;
  logic                 step_q,    step_d;
  logic                 err_q,     err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  quad_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_sync_filter (
    .clk       (clk),
    .reset     (reset),
    .raw_i     ({sq_a, sq_b}),
    .filt_o    (w_filt),
    .changed_o (w_changed)
  );

  assign w_new_ph = phase_enc(w_filt[1], w_filt[0]);
  // Modulo-4 phase difference: 1 = forward, 3 = backward, 2 = illegal jump
  assign w_delta  = w_new_ph - phase_q;

  // Decode each accepted filter change into a step, an error or a phase load
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    pos_d     = pos_q;
    dir_d     = dir_q;
    err_cnt_d = err_cnt_q;
    step_d    = 1'b0;
    err_d     = 1'b0;
    if (w_changed) begin
      phase_d = w_new_ph;
      if (state_q == ST_INIT) begin
        state_d = ST_TRACK;
      end else begin
        case (w_delta)
          2'd1: begin
            pos_d  = pos_q + C_POS_ONE;
            dir_d  = 1'b1;
            step_d = 1'b1;
          end
          2'd3: begin
            pos_d  = pos_q - C_POS_ONE;
            dir_d  = 1'b0;
            step_d = 1'b1;
          end
          2'd2: begin
            err_d = 1'b1;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + C_ERR_ONE;
            end
          end
          default: ;
        endcase
      end
    end
    // Clear overrides any concurrent step on the count only
    if (clear) begin
      pos_d = '0;
    end
  end

  // Decoder state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_INIT;
      phase_q   <= PH_0;
      pos_q     <= '0;
      dir_q     <= 1'b0;
      step_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign position  = pos_q;
  assign dir       = dir_q;
  assign step      = step_q;
  assign err       = err_q;
  assign err_count = err_cnt_q;

endmodule : quad_decoder
`default_nettype wire

// File: tb/tb_quad_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_quad_decoder
// Description : Self-checking bench for quad_decoder. Stimulus pushes the
//               expected event into a queue; a monitor pops and compares on
//               every step/err pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quad_decoder;

  localparam int CNT_W = 16;
  localparam int SYNC  = 2;
  localparam int FILT  = 3;
  localparam int LAT   = SYNC + FILT;
  localparam logic [7:0] C_SEQ = 8'b10_11_01_00;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sq_a = 1'b1;
  logic        sq_b = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] position;
  logic        dir, step, err;
  logic [7:0]  err_count;

  quad_decoder #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC), .FILT_LEN(FILT)) dut (
    .clk(clk), .reset(reset), .sq_a(sq_a), .sq_b(sq_b), .clear(clear),
    .position(position), .dir(dir), .step(step), .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit is_err;
    int pos;
    bit dir;
    int errc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int steps_seen = 0;

  // Reference model state
  int         m_pos = 0;
  bit         m_dir = 0;
  int         m_errc = 0;
  logic [1:0] m_ab = 2'b10;

  function automatic logic [1:0] seq_at(input int i);
    logic [7:0] s;
    s = C_SEQ;
    return s[7 - 2*(i % 4) -: 2];
  endfunction

  function automatic int ph_of(input logic [1:0] ab);
    for (int i = 0; i < 4; i++) if (seq_at(i) == ab) return i;
    return 0;
  endfunction

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Apply a new stable A/B value, predict its outcome, hold for 'hold' cycles.
  // With clr_land, clear is raised so it lands on the same edge as the step.
  task automatic drive(input logic [1:0] ab, input int hold, input bit clr_land);
    int d;
    exp_t e;
    d = (ph_of(ab) - ph_of(m_ab) + 4) % 4;
    e.cyc = cyc + 1 + LAT;
    if (d == 1 || d == 3) begin
      m_pos = (d == 1) ? ((m_pos + 1) & 16'hFFFF) : ((m_pos + 65535) & 16'hFFFF);
      m_dir = (d == 1);
      if (clr_land) m_pos = 0;
      e.is_err = 0; e.pos = m_pos; e.dir = m_dir; e.errc = m_errc;
      exp_q.push_back(e);
    end else if (d == 2) begin
      if (m_errc < 255) m_errc++;
      e.is_err = 1; e.pos = m_pos; e.dir = m_dir; e.errc = m_errc;
      exp_q.push_back(e);
    end
    m_ab = ab;
    {sq_a, sq_b} = ab;
    for (int k = 0; k < hold; k++) begin
      clear = clr_land && (k == LAT);
      @(negedge clk);
    end
    clear = 1'b0;
  endtask

  task automatic fwd(input int hold, input bit clr_land);
    drive(seq_at(ph_of(m_ab) + 1), hold, clr_land);
  endtask

  task automatic back(input int hold);
    drive(seq_at(ph_of(m_ab) + 3), hold, 1'b0);
  endtask

  task automatic jump(input int hold);
    drive(seq_at(ph_of(m_ab) + 2), hold, 1'b0);
  endtask

  task automatic do_clear();
    repeat (LAT + 3) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_pos = 0;
    chk("clear_position", position, 0);
    chk("clear_keeps_dir", dir, m_dir);
  endtask

  // Monitor: every pulse must match the oldest outstanding prediction
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      if (step && err) chk("step_err_exclusive", 1, 0);
      if (step || err) begin
        if (step) steps_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got step=%0d err=%0d expected none (cycle %0d)",
                   step, err, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("evt_cycle", cyc, e.cyc);
          chk("evt_is_err", err, e.is_err);
          chk("evt_position", position, e.pos);
          chk("evt_dir", dir, e.dir);
          chk("evt_err_count", err_count, e.errc);
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_event: got no pulse expected one at cycle %0d (now %0d)", e.cyc, cyc);
      end
    end
  end

  initial begin : stim
    int s0, r, hold, glen;
    logic [1:0] nxt;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_position", position, 0);
    chk("rst_dir", dir, 0);
    chk("rst_step", step, 0);
    chk("rst_err", err, 0);
    chk("rst_err_count", err_count, 0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("init_no_move", position, 0);

    // 40 forward steps, one edge per 8 clocks
    s0 = steps_seen;
    for (int i = 0; i < 40; i++) fwd(8, 1'b0);
    repeat (8) @(negedge clk);
    chk("fwd40_position", position, 40);
    chk("fwd40_dir", dir, 1);
    chk("fwd40_steps", steps_seen - s0, 40);
    chk("fwd40_err_count", err_count, 0);

    // Three full reverse cycles from zero
    do_clear();
    for (int i = 0; i < 12; i++) back(6);
    repeat (8) @(negedge clk);
    chk("rev12_position", position, 16'hFFF4);
    chk("rev12_dir", dir, 0);

    // Short glitches on A are discarded
    for (int i = 0; i < 4; i++) begin
      sq_a = ~m_ab[1];
      @(negedge clk);
      sq_a = m_ab[1];
      repeat (8) @(negedge clk);
    end
    chk("glitch_position", position, 16'hFFF4);
    chk("glitch_err_count", err_count, 0);

    // Clear landing on the same edge as a forward step
    fwd(LAT + 4, 1'b1);
    chk("clear_on_step_position", position, 0);

    // Randomized mix of legal steps, jumps, glitches and idle clears
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      hold = $urandom_range(FILT + 1, 9);
      if (r <= 3) fwd(hold, 1'b0);
      else if (r <= 6) back(hold);
      else if (r == 7) jump(hold);
      else if (r == 8) begin
        glen = $urandom_range(1, FILT - 1);
        if ($urandom_range(0, 1) == 1) sq_a = ~m_ab[1];
        else sq_b = ~m_ab[0];
        repeat (glen) @(negedge clk);
        {sq_a, sq_b} = m_ab;
        repeat (hold) @(negedge clk);
      end else do_clear();
    end
    repeat (LAT + 3) @(negedge clk);
    chk("rand_position", position, m_pos);
    chk("rand_err_count", err_count, m_errc);

    // Reset in the middle of a filter window after 10 steps
    for (int i = 0; i < 10; i++) fwd(6, 1'b0);
    repeat (2) @(negedge clk);
    nxt = seq_at(ph_of(m_ab) + 1);
    {sq_a, sq_b} = nxt;
    m_ab = nxt;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_position", position, 0);
    chk("midrst_dir", dir, 0);
    chk("midrst_step", step, 0);
    chk("midrst_err", err, 0);
    chk("midrst_err_count", err_count, 0);
    reset = 1'b0;
    m_pos = 0; m_dir = 0; m_errc = 0;
    s0 = steps_seen;
    repeat (12) @(negedge clk);
    chk("postrst_no_step", steps_seen - s0, 0);
    chk("postrst_position", position, 0);
    fwd(8, 1'b0);
    chk("postrst_track", position, 1);

    // Illegal jumps: single error then saturation
    jump(8);
    chk("jump1_err_count", err_count, 1);
    chk("jump1_position", position, 1);
    for (int i = 1; i < 300; i++) jump(5);
    repeat (LAT + 3) @(negedge clk);
    chk("jump300_err_count", err_count, 255);
    chk("jump300_position", position, 1);

    repeat (10) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_quad_decoder
`default_nettype wire

// File: doc/quad_decoder.md
# quad_decoder

Receive-side counterpart of the quadrature square-wave generator. Synchronizes and glitch-filters an asynchronous A/B quadrature pair, decodes each legal phase step into direction and a signed-free modulo position count, and flags illegal two-bit transitions. Sits between the external encoder pins (or a looped-back sq_wave_generator) and system logic that consumes position/velocity.

## Interface
- CNT_W, 16, position counter width
- SYNC_STAGES, 2, synchronizer flops per channel (≥2)
- FILT_LEN, 3, consecutive identical synced samples required to accept a new A/B value (≥1; 1 = no filtering)
- clk  input  1  sole clock; all logic on posedge
- reset  input  1  synchronous, active-high
- sq_a  input  1  channel A, asynchronous to clk
- sq_b  input  1  channel B, asynchronous to clk
- clear  input  1  synchronous position clear
- position  output  CNT_W  quadrature count, modulo 2^CNT_W
- dir  output  1  direction of last legal step (1 = forward)
- step  output  1  one-cycle pulse per legal step
- err  output  1  one-cycle pulse per illegal transition
- err_count  output  8  saturating illegal-transition count

## Operation
- Phase map of filtered (A,B): 10→0, 11→1, 01→2, 00→3. Forward = phase+1 mod 4, matching generator order 10→11→01→00→10.
- Filter: per pair, a candidate (A,B) replaces the filtered value only after FILT_LEN consecutive identical synced samples differing from it; shorter glitches are discarded.
- FSM: INIT, TRACK.
  - INIT: the first filtered value after reset loads the phase register; no step, no err; go to TRACK on the next edge.
  - TRACK, filtered phase change of +1: position+1, dir=1, step=1. Change of −1: position−1, dir=0, step=1. Change of ±2: err=1, err_count+1 (saturate at 255), position/dir unchanged, phase register still updated. No change: outputs hold, pulses low.
- Arithmetic: position wraps 2^CNT_W−1 → 0 forward, 0 → 2^CNT_W−1 backward, no flag.
- clear: position←0 next edge. Clear concurrent with a step: position=0 (clear wins), step and dir still report the step. clear does not affect err_count, dir, or FSM state.
- Reset (any time, including mid-filter): synchronizer, filter, and phase cleared; FSM→INIT. Outputs: position=0, dir=0, step=0, err=0, err_count=0.

## Timing
- Latency: a clean A/B change first sampled at edge E0 produces step/err/position update visible after edge E0+SYNC_STAGES+FILT_LEN (5 clocks at defaults).
- step and err are single-cycle, mutually exclusive, never asserted in INIT.
- Max accepted edge rate: one A/B change per FILT_LEN+1 clocks; faster input is filtered, or reported as err if two bits change within one filter window.
- position, dir, and err_count are registered and stable between events.

## Structure
- Package quad_pkg: phase encode function (A,B)→2-bit phase, phase constants PH_0..PH_3, FSM state enum {INIT, TRACK}, ERR_CNT_W=8.
- Sub-module quad_sync_filter: 2-bit synchronizer chain plus FILT_LEN stability counter; outputs the filtered pair and a one-cycle changed strobe. Top level holds the FSM, phase compare, counters.

## Test plan
- Loopback from sq_wave_generator, 40 generator clocks at 1 edge per 8 clk: position=40, dir=1, 40 step pulses, err_count=0.
- Reverse sequence 00→01→11→10 repeated 3 full cycles from position 0: position=2^16−12 (0xFFF4), dir=0.
- 1-cycle pulse on sq_a (glitch < FILT_LEN): no step, no err, position unchanged.
- Jump 10→01 held stable: one err pulse, err_count=1, position unchanged; repeat 300 times → err_count=255.
- clear asserted on the same edge a forward step lands: position=0, step=1, dir=1.
- Reset asserted mid-filter after 10 steps: all outputs 0 the next cycle; first post-reset filtered value yields no step.
